// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and sizing helpers for the serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic bit width_ok(input int width);
        return width >= 2 && width % 2 == 0;
    endfunction

    function automatic int idx_width(input int width);
        return (width / 2) <= 1 ? 1 : $clog2(width / 2);
    endfunction

endpackage

// File: rtl/add2_slice.sv
// add2_slice: combinational 2-bit adder slice with carry-in and carry-out.
module add2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       ci,
    output logic [1:0] s,
    output logic       co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {2'b00, ci};

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: WIDTH-bit add over WIDTH/2 cycles through one 2-bit slice.
// Define SERIAL_ADD_SUB_EN to add the sub port (a-b computed as a+~b+1).
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = width_ok(WIDTH) ? WIDTH / 2 : 1;
    localparam int IW = idx_width(WIDTH);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             cout_q, cout_d, out_valid_q, out_valid_d, in_ready_q, in_ready_d;
    logic             sub_i;
    logic [1:0]       slice_s;
    logic             slice_c;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_i = sub;
`else
    assign sub_i = 1'b0;
`endif

    add2_slice u_slice (
        .a  (a_q[{idx_q, 1'b0} +: 2]),
        .b  (b_q[{idx_q, 1'b0} +: 2]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_c)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                a_d        = a;
                b_d        = b ^ {WIDTH{sub_i}};
                carry_d    = sub_i;
                idx_d      = '0;
                sum_d      = '0;
                in_ready_d = 1'b0;
                state_d    = RUN;
            end
            RUN: begin
                sum_d[{idx_q, 1'b0} +: 2] = slice_s;
                carry_d = slice_c;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(N - 1)) begin
                    cout_d      = slice_c;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand registers need no reset: they are always reloaded on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of latency, hold, reset abort and throughput (WIDTH=8).
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sum;
    logic       cout;
    int         errors = 0;
    int         checks = 0;
    int         acc_edge;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts from IDLE; returns at the negedge where the result first appears.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s,
                          input logic [7:0] es, input logic ec, input string tag);
        @(negedge clk);
        in_valid = 1'b1; a = x; b = y; sub = s;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_busy"}, in_ready, 0);
        repeat (3) @(negedge clk);
        check({tag, "_early"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ready", in_ready, 1);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");

        @(negedge clk);
        in_valid = 1'b1; a = 8'hAA; b = 8'h55;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_partial", sum, 8'h03);
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_ready", in_ready, 1);
        repeat (6) @(negedge clk);
        check("abort_no_result", out_valid, 0);
        check("abort_sum_idle", sum, 0);

        out_ready = 1'b0;
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "hold_op");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'h11; b = 8'h22;
            check("hold_valid", out_valid, 1);
            check("hold_sum", sum, 8'h46);
            check("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("late_accept_busy", in_ready, 0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("late_valid", out_valid, 1);
        check("late_sum", sum, 8'h33);
        check("late_cout", cout, 0);

        @(negedge clk);
        in_valid = 1'b1; a = 8'h01; b = 8'h02;
        @(negedge clk);
        a = 8'h80; b = 8'h80;
        acc_edge = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 4) begin
                check("b2b1_sum", sum, 8'h03);
                check("b2b1_cout", cout, 0);
            end
            if (in_ready) begin
                acc_edge = n + 1;
                break;
            end
        end
        check("b2b_interval", acc_edge, 6);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("b2b2_valid", out_valid, 1);
        check("b2b2_sum", sum, 8'h00);
        check("b2b2_cout", cout, 1);

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, "sub_10_01");
        run_op(8'h01, 8'h10, 1'b1, 8'hF1, 1'b0, "sub_01_10");
        run_op(8'h22, 8'h11, 1'b0, 8'h33, 1'b0, "add_after_sub");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Sequencing controller that performs a WIDTH-bit addition by driving a single 2-bit adder slice over WIDTH/2 consecutive cycles, carrying between slices through a registered carry. It accepts operand pairs over a valid/ready input handshake and returns sum and carry-out over a valid/ready output handshake. It is the block that time-shares the narrow adder datapath across wide operands.

## Interface
- WIDTH, 8, operand width in bits; even, ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a/b (and sub) valid.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  addend / minuend.
- b  input  WIDTH  addend / subtrahend.
- sub  input  1  subtract select; present only with SERIAL_ADD_SUB_EN.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  final carry-out (no-borrow flag when subtracting).

## Operation
- States: IDLE, RUN, DONE. N = WIDTH/2 slices; slice counter idx, width clog2(N) (min 1).
- IDLE: in_ready=1. On in_valid&&in_ready: latch a, b (b inverted if subtracting), carry register ← carry-in (0, or 1 if subtracting), idx←0, sum←0, → RUN.
- RUN: in_ready=0. Each cycle slice adds a[2idx+1:2idx], b[2idx+1:2idx], carry; result written to sum[2idx+1:2idx], carry register ← slice carry, idx←idx+1. At idx==N-1 → DONE, cout ← slice carry.
- DONE: out_valid=1; sum, cout held stable. On out_ready → IDLE, out_valid←0. No accept in the same cycle (in_ready low in DONE).
- in_valid outside IDLE ignored; operands not sampled.
- Arithmetic modulo 2^WIDTH; cout is bit WIDTH of the true sum.
- Reset (any state, any time): state IDLE, idx 0, carry 0, sum 0, cout 0, out_valid 0; in_ready 1 after release. In-flight operation discarded, no output produced.

## Timing
- Accept on edge 0; slices processed on edges 1..N; out_valid high after edge N (latency N cycles; WIDTH=8 → 4).
- Result held until out_ready sampled high; IDLE after that edge, next accept possible on following edge.
- Minimum initiation interval N+2 cycles with out_ready tied high.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADD_SUB_EN defined: sub port present; sub=1 computes a−b as a+~b+1, cout=1 means a≥b (unsigned). sub sampled only at accept.
- Undefined: no sub port; carry-in always 0; addition only.

## Structure
- Package serial_add_pkg: state enum (IDLE, RUN, DONE), function for slice-count/counter width, WIDTH legality check constant.
- One sub-module add2_slice: combinational 2-bit adder with carry-in, outputs 2-bit sum and carry-out; instantiated once, fed by idx-selected operand bits.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, out_ready=1 → out_valid 4 cycles after accept, sum=0x96, cout=0.
- a=0xFF, b=0x01 → sum=0x00, cout=1 (carry ripples through all 4 slices).
- out_ready held low 5 cycles in DONE → sum/cout/out_valid stable; in_valid=1 with a=0x11 not accepted; accepted only after out_ready handshake and return to IDLE.
- Assert rst_n low during 2nd RUN cycle → immediately out_valid=0, sum=0, cout=0; after release in_ready=1, no stale result emerges.
- Back-to-back: 0x01+0x02 then 0x80+0x80 with out_ready=1 → sums 0x03/cout0 and 0x00/cout1, second accepted exactly N+2 cycles after first.
- With SERIAL_ADD_SUB_EN: sub=1, a=0x10, b=0x01 → sum=0x0F, cout=1; a=0x01, b=0x10 → sum=0xF1, cout=0.
